// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port between the sequencer (master) and the memory (slave).
// A fetch is pending while imem_req is high; the memory signals completion with imem_ack.
interface pc_sequencer_if;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE -> FETCH -> DECODE -> EXEC loop with fetch timeout and halt.
// Every output is a register or a direct copy of one; no input reaches an output combinationally.
module pc_sequencer #(
    parameter int          TIMEOUT  = 15,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           bsel,
    input  logic [7:0]           imm,
    input  logic [7:0]           reg_tgt,
    input  logic                 halt,
    pc_sequencer_if.master       imem,
    output logic [7:0]           pc,
    output logic [15:0]          ir,
    output logic                 exec_en,
    output logic                 halted,
    output logic                 fault,
    output logic [2:0]           state_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t          state_q;
    logic [7:0]      pc_q;
    logic [7:0]      pc_d;
    logic [15:0]     ir_q;
    logic [CW-1:0]   wait_q;
    logic            req_q;
    logic            exec_q;
    logic            halted_q;
    logic            fault_q;

    // 8-bit addition of imm gives sign-extended relative branching modulo 256.
    always_comb begin
        pc_d = pc_q + 8'd1;
        case (bsel)
            2'b00:   pc_d = pc_q + 8'd1;
            2'b01:   pc_d = pc_q + imm;
            2'b10:   pc_d = reg_tgt;
            2'b11:   pc_d = imm;
            default: pc_d = pc_q + 8'd1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            wait_q   <= '0;
            req_q    <= 1'b0;
            exec_q   <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            exec_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                        wait_q  <= '0;
                    end
                end
                S_FETCH: begin
                    // Ack is checked before the timeout so a last-cycle ack still succeeds.
                    if (imem.imem_ack) begin
                        ir_q    <= imem.imem_data;
                        wait_q  <= '0;
                        req_q   <= 1'b0;
                        state_q <= S_DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        wait_q   <= '0;
                        req_q    <= 1'b0;
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    state_q <= S_EXEC;
                    exec_q  <= 1'b1;
                end
                S_EXEC: begin
                    if (halt) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        pc_q    <= pc_d;
                        req_q   <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign ir             = ir_q;
    assign exec_en        = exec_q;
    assign halted         = halted_q;
    assign fault          = fault_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, fetch/exec timing, branch arithmetic,
// jumps, fetch timeout with ack-wins boundary, halt, and asynchronous reset mid-fetch.
module tb_pc_sequencer;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  bsel = 2'b00;
  logic [7:0]  imm = 8'h00;
  logic [7:0]  reg_tgt = 8'h00;
  logic        halt = 1'b0;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        exec_en;
  logic        halted;
  logic        fault;
  logic [2:0]  state_o;

  int n_vec = 0;
  int n_err = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(.TIMEOUT(15), .RESET_PC(8'h00)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bsel    (bsel),
    .imm     (imm),
    .reg_tgt (reg_tgt),
    .halt    (halt),
    .imem    (bus.master),
    .pc      (pc),
    .ir      (ir),
    .exec_en (exec_en),
    .halted  (halted),
    .fault   (fault),
    .state_o (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; halt = 1'b0; bsel = 2'b00; imm = 8'h00; reg_tgt = 8'h00;
    bus.imem_ack = 1'b0; bus.imem_data = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Assumes the DUT is in FETCH; completes one zero-wait instruction.
  task automatic run_instr(input logic [1:0] b, input logic [7:0] im,
                           input logic [7:0] tgt, input logic h, input logic [15:0] data);
    bus.imem_ack = 1'b1; bus.imem_data = data;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    bsel = b; imm = im; reg_tgt = tgt; halt = h;
    tick();
    halt = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_data = 16'h0000;
    #3;
    n_vec++; if (state_o !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d exp %0d", state_o, ST_IDLE); end
    n_vec++; if (pc !== 8'h00) begin n_err++; $display("FAIL reset_pc got %h exp %h", pc, 8'h00); end
    n_vec++; if (ir !== 16'h0000) begin n_err++; $display("FAIL reset_ir got %h exp %h", ir, 16'h0000); end
    n_vec++; if ({bus.imem_req, exec_en, halted, fault} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b exp %b", {bus.imem_req, exec_en, halted, fault}, 4'b0000); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_vec++; if (state_o !== ST_IDLE || bus.imem_req !== 1'b0) begin n_err++; $display("FAIL idle_wait got st=%0d req=%b exp st=%0d req=0", state_o, bus.imem_req, ST_IDLE); end
  endtask

  task automatic test_basic();
    do_reset();
    do_start();
    n_vec++; if (state_o !== ST_FETCH || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin n_err++; $display("FAIL basic_fetch got st=%0d req=%b addr=%h exp st=1 req=1 addr=00", state_o, bus.imem_req, bus.imem_addr); end
    bus.imem_ack = 1'b1; bus.imem_data = 16'h1234;
    tick();
    n_vec++; if (state_o !== ST_DECODE || ir !== 16'h1234 || exec_en !== 1'b0) begin n_err++; $display("FAIL basic_decode got st=%0d ir=%h en=%b exp st=2 ir=1234 en=0", state_o, ir, exec_en); end
    bus.imem_data = 16'h5555;
    tick();
    n_vec++; if (exec_en !== 1'b1 || ir !== 16'h1234 || bus.imem_req !== 1'b0) begin n_err++; $display("FAIL basic_exec got en=%b ir=%h req=%b exp en=1 ir=1234 req=0", exec_en, ir, bus.imem_req); end
    bus.imem_ack = 1'b0; bsel = 2'b00;
    tick();
    n_vec++; if (pc !== 8'h01 || exec_en !== 1'b0 || bus.imem_addr !== 8'h01 || state_o !== ST_FETCH) begin n_err++; $display("FAIL basic_next got pc=%h en=%b addr=%h st=%0d exp pc=01 en=0 addr=01 st=1", pc, exec_en, bus.imem_addr, state_o); end
  endtask

  task automatic test_branch();
    run_instr(2'b11, 8'h05, 8'h00, 1'b0, 16'h0001);
    n_vec++; if (pc !== 8'h05) begin n_err++; $display("FAIL br_setup got %h exp %h", pc, 8'h05); end
    run_instr(2'b01, 8'hFD, 8'h00, 1'b0, 16'h0002);
    n_vec++; if (pc !== 8'h02) begin n_err++; $display("FAIL br_back3 got %h exp %h", pc, 8'h02); end
    run_instr(2'b01, 8'hFC, 8'h00, 1'b0, 16'h0003);
    n_vec++; if (pc !== 8'hFE) begin n_err++; $display("FAIL br_wrap_neg got %h exp %h", pc, 8'hFE); end
    run_instr(2'b01, 8'h01, 8'h00, 1'b0, 16'h0004);
    n_vec++; if (pc !== 8'hFF) begin n_err++; $display("FAIL br_fwd1 got %h exp %h", pc, 8'hFF); end
    run_instr(2'b00, 8'h77, 8'h00, 1'b0, 16'h0005);
    n_vec++; if (pc !== 8'h00) begin n_err++; $display("FAIL inc_wrap got %h exp %h", pc, 8'h00); end
  endtask

  task automatic test_jump();
    run_instr(2'b10, 8'h11, 8'hA0, 1'b0, 16'h0006);
    n_vec++; if (pc !== 8'hA0 || bus.imem_addr !== 8'hA0 || bus.imem_req !== 1'b1) begin n_err++; $display("FAIL jr got pc=%h addr=%h req=%b exp A0 A0 1", pc, bus.imem_addr, bus.imem_req); end
    run_instr(2'b11, 8'h3C, 8'h99, 1'b0, 16'h0007);
    n_vec++; if (pc !== 8'h3C || bus.imem_addr !== 8'h3C) begin n_err++; $display("FAIL ji got pc=%h addr=%h exp 3C 3C", pc, bus.imem_addr); end
    n_vec++; if (ir !== 16'h0007) begin n_err++; $display("FAIL ji_ir got %h exp %h", ir, 16'h0007); end
  endtask

  task automatic test_timeout();
    do_reset();
    do_start();
    repeat (14) tick();
    n_vec++; if (state_o !== ST_FETCH || fault !== 1'b0 || bus.imem_req !== 1'b1) begin n_err++; $display("FAIL to_pre got st=%0d fault=%b req=%b exp st=1 fault=0 req=1", state_o, fault, bus.imem_req); end
    tick();
    n_vec++; if (fault !== 1'b1 || halted !== 1'b1 || bus.imem_req !== 1'b0 || state_o !== ST_HALT) begin n_err++; $display("FAIL to_fault got fault=%b halted=%b req=%b st=%0d exp 1 1 0 4", fault, halted, bus.imem_req, state_o); end
    n_vec++; if (pc !== 8'h00 || ir !== 16'h0000) begin n_err++; $display("FAIL to_keep got pc=%h ir=%h exp 00 0000", pc, ir); end
    bus.imem_ack = 1'b1; bus.imem_data = 16'hFFFF; start = 1'b1;
    repeat (3) tick();
    n_vec++; if (state_o !== ST_HALT || ir !== 16'h0000 || bus.imem_req !== 1'b0 || fault !== 1'b1) begin n_err++; $display("FAIL to_sticky got st=%0d ir=%h req=%b fault=%b exp 4 0000 0 1", state_o, ir, bus.imem_req, fault); end
    bus.imem_ack = 1'b0; start = 1'b0;
  endtask

  task automatic test_ack_wins();
    do_reset();
    do_start();
    repeat (14) tick();
    bus.imem_ack = 1'b1; bus.imem_data = 16'hBEEF;
    tick();
    bus.imem_ack = 1'b0;
    n_vec++; if (state_o !== ST_DECODE || fault !== 1'b0 || ir !== 16'hBEEF) begin n_err++; $display("FAIL ack_wins got st=%0d fault=%b ir=%h exp 2 0 BEEF", state_o, fault, ir); end
  endtask

  task automatic test_halt();
    do_reset();
    do_start();
    run_instr(2'b11, 8'h10, 8'h00, 1'b0, 16'h0010);
    n_vec++; if (pc !== 8'h10) begin n_err++; $display("FAIL halt_setup got %h exp %h", pc, 8'h10); end
    run_instr(2'b11, 8'h40, 8'h00, 1'b1, 16'h0F0F);
    n_vec++; if (halted !== 1'b1 || pc !== 8'h10 || state_o !== ST_HALT || bus.imem_req !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL halt got halted=%b pc=%h st=%0d req=%b fault=%b exp 1 10 4 0 0", halted, pc, state_o, bus.imem_req, fault); end
    bus.imem_ack = 1'b1; bus.imem_data = 16'hAAAA; start = 1'b1;
    repeat (2) tick();
    bus.imem_ack = 1'b0; start = 1'b0;
    n_vec++; if (ir !== 16'h0F0F || state_o !== ST_HALT || exec_en !== 1'b0) begin n_err++; $display("FAIL halt_ignore got ir=%h st=%0d en=%b exp 0F0F 4 0", ir, state_o, exec_en); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    do_start();
    run_instr(2'b11, 8'h33, 8'h00, 1'b0, 16'h1111);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (pc !== 8'h00 || state_o !== ST_IDLE || bus.imem_req !== 1'b0 || ir !== 16'h0000) begin n_err++; $display("FAIL mid_rst got pc=%h st=%0d req=%b ir=%h exp 00 0 0 0000", pc, state_o, bus.imem_req, ir); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.imem_ack = 1'b1; bus.imem_data = 16'hABCD;
    repeat (3) tick();
    n_vec++; if (state_o !== ST_IDLE || bus.imem_req !== 1'b0 || ir !== 16'h0000) begin n_err++; $display("FAIL mid_idle got st=%0d req=%b ir=%h exp 0 0 0000", state_o, bus.imem_req, ir); end
    bus.imem_ack = 1'b0;
    do_start();
    n_vec++; if (state_o !== ST_FETCH || bus.imem_addr !== 8'h00 || bus.imem_req !== 1'b1) begin n_err++; $display("FAIL mid_restart got st=%0d addr=%h req=%b exp 1 00 1", state_o, bus.imem_addr, bus.imem_req); end
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_data = 16'h0000;
    test_reset();
    test_basic();
    test_branch();
    test_jump();
    test_timeout();
    test_ack_wins();
    test_halt();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum FETCH wait cycles before a fetch fault.
REQ-002 Parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  leave IDLE and begin fetching; sampled in IDLE only.
REQ-007 bsel  input  2  resolved branch select: 00 next, 01 relative taken, 10 jump-register, 11 jump-immediate.
REQ-008 imm  input  8  branch operand: two's-complement offset for 01, absolute target for 11.
REQ-009 reg_tgt  input  8  register-file target for 10.
REQ-010 halt  input  1  decoded halt instruction; sampled in EXEC only.
REQ-011 imem_ack  input  1  instruction memory data-valid; sampled in FETCH only.
REQ-012 imem_data  input  16  instruction word, valid when imem_ack=1.
REQ-013 imem_req  output  1  fetch request, high for the whole FETCH state.
REQ-014 imem_addr  output  8  fetch address, equals pc while imem_req=1.
REQ-015 pc  output  8  program counter.
REQ-016 ir  output  16  instruction register.
REQ-017 exec_en  output  1  datapath execute enable, high in EXEC only.
REQ-018 halted  output  1  high in HALT.
REQ-019 fault  output  1  sticky fetch-timeout flag.

Function
REQ-020 States: IDLE, FETCH, DECODE, EXEC, HALT; encoding free.
REQ-021 IDLE: start=1 -> FETCH next cycle; otherwise stay.
REQ-022 FETCH: imem_req=1, imem_addr=pc, wait counter increments each cycle without ack.
REQ-023 FETCH with imem_ack=1: ir <= imem_data, counter cleared, -> DECODE next cycle.
REQ-024 FETCH without ack for TIMEOUT consecutive cycles: fault <= 1, -> HALT; ir and pc unchanged.
REQ-025 An ack on the same cycle the counter reaches TIMEOUT counts as success (ack wins).
REQ-026 DECODE: one cycle, no output changes other than state, -> EXEC.
REQ-027 EXEC: exec_en=1 for exactly one cycle; bsel, imm, reg_tgt, halt sampled on the clock edge ending EXEC.
REQ-028 EXEC, halt=0: pc updated per bsel, -> FETCH.
REQ-029 bsel 00: pc <= pc+1 modulo 256 (8'hFF wraps to 8'h00).
REQ-030 bsel 01: pc <= pc + sign-extended imm, modulo 256 (e.g. 8'h02 + 8'hFC = 8'hFE).
REQ-031 bsel 10: pc <= reg_tgt; bsel 11: pc <= imm.
REQ-032 EXEC, halt=1: pc unchanged regardless of bsel, -> HALT.
REQ-033 HALT: terminal; only rst_n exits; start and imem_ack ignored.
REQ-034 Instruction latency: start to first exec_en = 3 cycles with zero-wait ack; steady state 3 cycles per instruction plus memory wait cycles.
REQ-035 imem_ack outside FETCH is ignored and does not modify ir.

Reset
REQ-036 rst_n=0 immediately forces: state IDLE, pc=RESET_PC, ir=16'h0000, wait counter 0, imem_req=0, exec_en=0, halted=0, fault=0.
REQ-037 Reset asserted mid-FETCH or mid-EXEC aborts the operation with no pc update; after release the block waits in IDLE for start.
REQ-038 All outputs are registered or decoded from state only; none depends combinationally on inputs.

Verification
REQ-039 Reset, start=1, ack in the first FETCH cycle with imem_data=16'h1234, bsel=00 -> ir=16'h1234, exec_en pulse 3 cycles after start, pc 00->01.
REQ-040 pc=8'h05, bsel=01, imm=8'hFD -> pc=8'h02; pc=8'hFF, bsel=00 -> pc=8'h00.
REQ-041 bsel=10, reg_tgt=8'hA0 -> pc=8'hA0; bsel=11, imm=8'h3C -> pc=8'h3C; next imem_addr matches.
REQ-042 No ack for 15 FETCH cycles -> fault=1, halted=1, imem_req=0; subsequent ack and start ignored.
REQ-043 halt=1 in EXEC with bsel=11, imm=8'h40 at pc=8'h10 -> halted=1, pc stays 8'h10.
REQ-044 rst_n pulsed low during a 5-cycle ack wait -> pc=RESET_PC, state IDLE, no fetch until start=1.
